// File: rtl/mem_stage_pkg.sv
// Shared codes for the MEM stage: funct3 access sizes, writeback selects, FSM states,
// and the byte-enable generator used for data-memory writes.
package mem_stage_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam logic [1:0] WB_MEM     = 2'b00;
  localparam logic [1:0] WB_ALU     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;
  localparam logic [1:0] WB_ALU_RSV = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Only size[1:0] matters: BU/HU share lanes with B/H.
  function automatic logic [3:0] be_gen(input logic [2:0] size, input logic [1:0] offset);
    case (size[1:0])
      2'b00:   be_gen = 4'b0001 << offset;
      2'b01:   be_gen = offset[1] ? 4'b1100 : 4'b0011;
      default: be_gen = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load aligner: picks the byte/half lane from the read word and
// sign- or zero-extends it according to funct3.
module load_extend
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      size,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    // offset[0] is ignored for halves; misalignment is handled upstream.
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (size)
      MEM_B:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      MEM_H:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
      MEM_BU:  data = {{(XLEN-8){1'b0}}, byte_lane};
      MEM_HU:  data = {{(XLEN-16){1'b0}}, half_lane};
      MEM_W:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32 MEM stage: req/ack data-memory handshake, B/H/W loads and stores, MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into wb_exc retirements.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int PC_INC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     alu_in,
  input  logic [XLEN-1:0]     DataB_in,
  input  logic [31:0]         inst_in,
  input  logic                MemRd,
  input  logic                MemRW,
  input  logic [2:0]          MemSize,
  input  logic [1:0]          WBSel,
  input  logic                RegWEn,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [XLEN/8-1:0]   dmem_be,
  output logic [XLEN-1:0]     dmem_wdata,
  input  logic                dmem_ack,
  input  logic [XLEN-1:0]     dmem_rdata,
  output logic                wb_valid,
  output logic [XLEN-1:0]     DataD,
  output logic [31:0]         inst_out,
  output logic                RegWEn_out,
  output logic                wb_exc
);

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] size,
                                                  input logic [XLEN-1:0] d);
    case (size[1:0])
      2'b00:   store_lanes = {(XLEN/8){d[7:0]}};
      2'b01:   store_lanes = {(XLEN/16){d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0]      sel,
                                             input logic [XLEN-1:0] mem_v,
                                             input logic [XLEN-1:0] alu_v,
                                             input logic [XLEN-1:0] pc_v);
    case (sel)
      WB_MEM:     wb_mux = mem_v;
      WB_PC:      wb_mux = pc_v + XLEN'(PC_INC);
      WB_ALU:     wb_mux = alu_v;
      WB_ALU_RSV: wb_mux = alu_v;
      default:    wb_mux = alu_v;
    endcase
  endfunction

  state_t            state;
  logic              is_mem;
  logic              misalign;
  logic              issue;

  logic [XLEN-1:0]   addr_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [XLEN-1:0]   pc_p0;
  logic [31:0]       inst_p0;
  logic [XLEN/8-1:0] be_p0;
  logic [2:0]        size_p0;
  logic [1:0]        wbsel_p0;
  logic              we_p0;
  logic              regwen_p0;

  logic [XLEN-1:0]   load_data;

  logic              retire;
  logic [XLEN-1:0]   nxt_data;
  logic [31:0]       nxt_inst;
  logic              nxt_wen;
  logic              nxt_exc;

  logic [XLEN-1:0]   data_p1;
  logic [31:0]       inst_p1;
  logic              vld_p1;
  logic              wen_p1;
  logic              exc_p1;

  // A store wins when both MemRd and MemRW are asserted.
  assign is_mem = MemRd | MemRW;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = is_mem &&
                    (((MemSize[1:0] == MEM_H[1:0]) && alu_in[0]) ||
                     ((MemSize[1:0] == MEM_W[1:0]) && (alu_in[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign issue = (state == IDLE) && in_valid && is_mem && !misalign;

  // EX -> request register: held stable for the whole WAIT phase.
  always_ff @(posedge clk) begin
    if (issue) begin
      addr_p0   <= alu_in;
      wdata_p0  <= store_lanes(MemSize, DataB_in);
      be_p0     <= be_gen(MemSize, alu_in[1:0]);
      size_p0   <= MemSize;
      wbsel_p0  <= WBSel;
      we_p0     <= MemRW;
      regwen_p0 <= RegWEn;
      pc_p0     <= pc;
      inst_p0   <= inst_in;
    end
  end

  assign in_ready   = (state == IDLE);
  assign dmem_req   = (state == WAIT);
  assign dmem_we    = (state == WAIT) && we_p0;
  assign dmem_addr  = {addr_p0[ADDR_W-1:2], 2'b00};
  assign dmem_be    = be_p0;
  assign dmem_wdata = wdata_p0;

  load_extend #(
    .XLEN (XLEN)
  ) u_load_extend (
    .rdata  (dmem_rdata),
    .size   (size_p0),
    .offset (addr_p0[1:0]),
    .data   (load_data)
  );

  always_comb begin
    retire   = 1'b0;
    nxt_data = '0;
    nxt_inst = '0;
    nxt_wen  = 1'b0;
    nxt_exc  = 1'b0;
    if (state == WAIT) begin
      if (dmem_ack) begin
        retire   = 1'b1;
        nxt_data = wb_mux(wbsel_p0, load_data, addr_p0, pc_p0);
        nxt_inst = inst_p0;
        nxt_wen  = regwen_p0 && !we_p0;
      end
    end else if (in_valid) begin
      if (misalign) begin
        retire   = 1'b1;
        nxt_data = alu_in;
        nxt_inst = inst_in;
        nxt_exc  = 1'b1;
      end else if (!is_mem) begin
        retire   = 1'b1;
        nxt_data = wb_mux(WBSel, '0, alu_in, pc);
        nxt_inst = inst_in;
        nxt_wen  = RegWEn;
      end
    end
  end

  // FSM and MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      wen_p1  <= 1'b0;
      exc_p1  <= 1'b0;
      data_p1 <= '0;
      inst_p1 <= '0;
    end else begin
      if (state == IDLE) begin
        if (issue) state <= WAIT;
      end else if (dmem_ack) begin
        state <= IDLE;
      end
      vld_p1 <= retire;
      wen_p1 <= nxt_wen;
      exc_p1 <= nxt_exc;
      if (retire) begin
        data_p1 <= nxt_data;
        inst_p1 <= nxt_inst;
      end
    end
  end

  assign wb_valid   = vld_p1;
  assign DataD      = data_p1;
  assign inst_out   = inst_p1;
  assign RegWEn_out = wen_p1;
  assign wb_exc     = exc_p1;

endmodule
